// File: rtl/mac_bit_column_scheduler.sv
// Bit-column scheduler for one bit-serial vertical MAC unit.
// Walks the set bits of a weight group's column mask from MSB to LSB and
// skips zero-contribution columns. Each column result is accumulated at
// its bit weight, and the full-precision sum is handed off with valid/ready.
module mac_bit_column_scheduler #(
   parameter int unsigned W_PREC        = 8,
   parameter int unsigned SUM_ACT_WIDTH = 11,
   parameter int unsigned ACC_WIDTH     = 19,
   localparam int unsigned COL_W        = (W_PREC > 1) ? $clog2(W_PREC) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W_PREC-1:0]        col_mask,
   input  logic                     skip_zero_mode,
   output logic [COL_W-1:0]         col_sel,
   output logic                     col_valid,
   output logic                     is_msb,
   output logic                     is_skip_zero,
   input  logic [SUM_ACT_WIDTH-1:0] mac_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACC_WIDTH-1:0]     acc_out,
   output logic                     busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [W_PREC-1:0]      pending_q, pending_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic                   skz_q, skz_d;

   logic [COL_W-1:0]       col_enc;
   logic                   last_col;
   logic signed [ACC_WIDTH-1:0] mac_ext;
   logic signed [ACC_WIDTH-1:0] mac_shifted;

   // Priority encoder: index of the highest pending column (later hits win).
   always_comb begin
      col_enc = '0;
      for (int unsigned c = 0; c < W_PREC; c++) begin
         if (pending_q[c]) col_enc = COL_W'(c);
      end
   end

   // Column-result alignment: sign-extend, then weight by the column position.
   always_comb begin
      mac_ext     = {{(ACC_WIDTH-SUM_ACT_WIDTH){mac_result[SUM_ACT_WIDTH-1]}}, mac_result};
      mac_shifted = mac_ext <<< col_enc;
      last_col    = ((pending_q & (pending_q - W_PREC'(1))) == '0);
   end

   // Next-state logic and datapath/handshake outputs.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      acc_d     = acc_q;
      skz_d     = skz_q;
      in_ready  = 1'b0;
      col_valid = 1'b0;
      col_sel   = '0;
      is_msb    = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               pending_d = col_mask;
               skz_d     = skip_zero_mode;
               acc_d     = '0;
               state_d   = (col_mask != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            col_valid = 1'b1;
            col_sel   = col_enc;
            is_msb    = (col_enc == COL_W'(W_PREC-1));
            acc_d     = acc_q + mac_shifted;
            pending_d = pending_q & ~(W_PREC'(1) << col_enc);
            if (last_col) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign acc_out      = acc_q;
   assign is_skip_zero = skz_q;
   assign busy         = (state_q != IDLE);

   // State and datapath registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         acc_q     <= '0;
         skz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         acc_q     <= acc_d;
         skz_q     <= skz_d;
      end
   end

endmodule

// File: doc/mac_bit_column_scheduler.md
Name: mac_bit_column_scheduler

Overview:
Sequences one bit-serial vertical MAC unit across the weight bit-columns of a weight group, processing columns from MSB to LSB. Columns flagged as zero-contribution are skipped, so they cost no cycles. For each issued column it drives the column select and the is_msb / is_skip_zero mode bits into the MAC datapath. It accumulates the returned column result, shifted by the column's bit position, into a full-precision partial sum, and hands that sum downstream with a valid/ready handshake.

Parameters:
W_PREC, 8, weight precision = number of bit-columns per group
SUM_ACT_WIDTH, 11, width of signed MAC column result (mac_result)
ACC_WIDTH, 19, width of signed accumulated output; must be >= SUM_ACT_WIDTH + W_PREC
COL_W (localparam), $clog2(W_PREC), column index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  new weight group descriptor available
in_ready  out  1  scheduler can accept a descriptor
col_mask  in  W_PREC  bit c=1 means column c must be processed; 0 means its contribution is zero, skip it
skip_zero_mode  in  1  mode for this group, latched on accept
col_sel  out  COL_W  bit-column currently issued to datapath
col_valid  out  1  col_sel / mode bits valid this cycle; mac_result sampled
is_msb  out  1  issued column is the sign column (W_PREC-1)
is_skip_zero  out  1  latched skip_zero_mode, to datapath
mac_result  in  SUM_ACT_WIDTH  signed combinational column result from MAC for col_sel
out_valid  out  1  acc_out holds final sum
out_ready  in  1  downstream accepts acc_out
acc_out  out  ACC_WIDTH  signed accumulated partial sum
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pending mask=0; acc=0; is_skip_zero=0. All outputs 0 except in_ready=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; col_valid=0; col_sel=0; is_msb=0.
  - Accept on in_valid&&in_ready: latch pending<=col_mask and is_skip_zero<=skip_zero_mode; acc<=0.
  - If col_mask!=0, go to RUN; otherwise go to DONE with acc=0.
- RUN:
  - in_ready=0; col_valid=1.
  - col_sel = index of the highest set bit in pending, via a combinational priority encoder.
  - is_msb = (col_sel==W_PREC-1).
  - Each cycle: acc <= acc + (sign_extend(mac_result, ACC_WIDTH) <<< col_sel), and the col_sel bit in pending is cleared.
  - When pending has exactly one bit set, go to DONE after that cycle.
  - RUN lasts exactly popcount(col_mask) cycles.
  - Sign handling (negation at the MSB column) is done by the datapath; the scheduler adds mac_result as-is.
- DONE:
  - out_valid=1; acc_out=acc, held stable while out_valid&&!out_ready. in_ready=0.
  - On out_ready: go to IDLE; out_valid deasserts the next cycle.
  - A new descriptor cannot be accepted in the same cycle as the output handshake.
- Latency: accept edge to out_valid = popcount(col_mask)+1 cycles; empty mask = 1 cycle. Throughput: one group per popcount+2 cycles minimum.
- acc_out: driven from the acc register in every state. It is only meaningful while out_valid=1. It is cleared on the next accept, not on output handshake.
- is_skip_zero: holds its last latched value through DONE and IDLE until the next accept.
- Arithmetic:
  - Two's complement throughout.
  - No saturation; ACC_WIDTH is sized so that W_PREC columns of full-scale mac_result cannot overflow.
  - Shift is arithmetic on the sign-extended value.
- in_valid while busy: ignored, because in_ready=0. The descriptor must be held by the source.
- col_mask / skip_zero_mode changing during RUN: no effect, since both are latched.
- Reset mid-RUN or mid-DONE: immediate return to reset values. The in-flight group is discarded and no out_valid pulse is produced.

Test Plan:
- Mask 8'hFF, skip_zero_mode=1, mac_result=+1 every column -> col_sel 7,6,...,0 on consecutive cycles. is_msb=1 only on the first cycle, is_skip_zero=1 throughout. out_valid 9 cycles after accept with acc_out=255.
- Mask 8'b1000_0001, bench returns -3 for col7 and +5 for col0 -> exactly 2 RUN cycles (col_sel 7 then 0). acc_out = -379, i.e. 19'h7FE85.
- Mask 8'h00 -> no col_valid pulse; out_valid on the cycle after accept; acc_out=0; in_ready low only during DONE.
- Mask 8'b0010_0100, mac_result=-1024 for both columns -> acc_out = -1024*(32+4) = -36864. No overflow at ACC_WIDTH=19.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> acc_out stable and in_ready=0 with in_valid held high. Release -> IDLE, then the next group is accepted one cycle later.
- Assert rst_n=0 asynchronously in the 3rd RUN cycle of an 8'hFF group -> outputs return to reset values without waiting for a clock edge. No out_valid is produced. A new group after reset yields a correct, independent sum.
